ex_muldiv_sequencer: RTL and testbench

- Multi-cycle multiply/divide controller beside the EX-stage ALU.
- Accepts one MUL/MULH/DIV/REM request from the ID/EX register and runs it iteratively (one bit per cycle).
- Holds `stall` high so the front of the pipeline and the EX/MEM capture wait, then presents the result and destination register for one cycle.
- Kills the operation on a pipeline flush.

---
 rtl/ex_muldiv_sequencer_if.sv | 32 +++
 rtl/ex_muldiv_sequencer.sv | 166 ++++++++++++++++
 tb/tb_ex_muldiv_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// ex_muldiv_sequencer_if : request/result bundle between the EX stage and the
//                          iterative multiply/divide sequencer.   Rev 1.0
// ============================================================================
interface ex_muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [4:0]       dest_reg;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [4:0]       result_reg;
  logic             div_by_zero;

  modport master (
    output start, op, operand_a, operand_b, dest_reg, flush,
    input  stall, busy, done, result, result_reg, div_by_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b, dest_reg, flush,
    output stall, busy, done, result, result_reg, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// ex_muldiv_sequencer : one-bit-per-cycle unsigned MUL/MULH/DIV/REM engine
//                       that stalls the pipeline while it iterates.  Rev 1.0
// ============================================================================
module ex_muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  wire logic              clk,
  input  wire logic              rst,
  ex_muldiv_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [1:0]         op_q, op_d;
  logic [4:0]         dest_q, dest_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [4:0]         result_reg_q, result_reg_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  // Datapath for one iteration. acc holds {hi, lo}: for multiply hi is the
  // partial product and lo the remaining multiplier bits; for divide hi is
  // the partial remainder and lo the dividend shifting into the quotient.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_diff;
  logic               rem_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_next;
  logic [WIDTH-1:0]   step_result;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // The shifted remainder needs WIDTH+1 bits; a non-negative difference
    // always fits back into WIDTH bits because the remainder stays below
    // the divisor.
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    rem_ge   = (rem_sh >= {1'b0, opnd_q});
    rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
    div_next = rem_ge ? {rem_diff,          acc_q[WIDTH-2:0], 1'b1}
                      : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    step_next = op_q[1] ? div_next : mul_next;
    case (op_q)
      2'b00:   step_result = step_next[WIDTH-1:0];
      2'b01:   step_result = step_next[2*WIDTH-1:WIDTH];
      2'b10:   step_result = step_next[WIDTH-1:0];
      default: step_result = step_next[2*WIDTH-1:WIDTH];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    opnd_d       = opnd_q;
    op_d         = op_q;
    dest_d       = dest_q;
    result_d     = result_q;
    result_reg_d = result_reg_q;
    dbz_d        = dbz_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          if (bus.op[1] && (bus.operand_b == '0)) begin
            state_d      = DONE;
            result_d     = bus.op[0] ? bus.operand_a : {WIDTH{1'b1}};
            result_reg_d = bus.dest_reg;
            dbz_d        = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = '0;
            op_d    = bus.op;
            dest_d  = bus.dest_reg;
            if (bus.op[1]) begin
              acc_d  = {{WIDTH{1'b0}}, bus.operand_a};
              opnd_d = bus.operand_b;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, bus.operand_b};
              opnd_d = bus.operand_a;
            end
          end
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d      = DONE;
            result_d     = step_result;
            result_reg_d = dest_q;
            dbz_d        = 1'b0;
          end
        end
      end
      default: begin
        // start is still the instruction just completed, so it is ignored.
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      opnd_q       <= '0;
      op_q         <= '0;
      dest_q       <= '0;
      result_q     <= '0;
      result_reg_q <= '0;
      dbz_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      opnd_q       <= opnd_d;
      op_q         <= op_d;
      dest_q       <= dest_d;
      result_q     <= result_d;
      result_reg_q <= result_reg_d;
      dbz_q        <= dbz_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  // Combinational so the request cycle itself already holds the pipeline.
  assign bus.stall       = (((state_q == IDLE) && bus.start) || (state_q == RUN))
                           && !bus.flush;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.result_reg  = result_reg_q;
  assign bus.div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ex_muldiv_sequencer : scoreboard bench with directed and random ops
//                          against an arithmetic reference model.  Rev 1.0
// ============================================================================
module tb_ex_muldiv_sequencer;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   rd;
    logic         dbz;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  logic [W-1:0] last_res = '0;

  ex_muldiv_sequencer_if #(.WIDTH(W)) bus ();

  ex_muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, required no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", 64'(bus.result), 64'(e.res));
        chk("result_reg", 64'(bus.result_reg), 64'(e.rd));
        chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] rd, output int dcyc);
    exp_t e;
    int   t0;
    int   sc;
    bit   seen;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.dest_reg  = rd;
    t0    = cyc;
    e.res = model(op, a, b);
    e.rd  = rd;
    e.dbz = op[1] && (b == 0);
    e.cyc = t0 + (e.dbz ? 1 : W + 1);
    sb_q.push_back(e);
    last_res = e.res;
    sc   = 0;
    seen = 1'b0;
    dcyc = -1;
    for (int k = 0; k < W + 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.stall) sc++;
      if (bus.done) begin
        seen = 1'b1;
        dcyc = cyc;
      end
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    else       chk("stall_cycles", 64'(sc), 64'(e.dbz ? 1 : W + 1));
  endtask

  initial begin
    int d1, d2, dd, t0;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    bus.start = 1'b0; bus.op = 2'd0; bus.operand_a = '0; bus.operand_b = '0;
    bus.dest_reg = 5'd0; bus.flush = 1'b0;

    #12;
    chk("reset_outputs", {bus.busy, bus.stall, bus.done, bus.div_by_zero, 5'(bus.result_reg), W'(bus.result)}, 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op(2'd0, 32'd7, 32'd6, 5'd5, dd);                      idle(1);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, dd);      idle(1);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, dd);      idle(1);
    run_op(2'd2, 32'd100, 32'd7, 5'd8, dd);                    idle(1);
    run_op(2'd3, 32'd100, 32'd7, 5'd9, dd);                    idle(1);
    run_op(2'd2, 32'd5, 32'd9, 5'd10, dd);                     idle(1);
    run_op(2'd3, 32'd5, 32'd9, 5'd11, dd);                     idle(1);
    run_op(2'd2, 32'd5, 32'd0, 5'd12, dd);                     idle(1);
    run_op(2'd3, 32'd5, 32'd0, 5'd13, dd);                     idle(1);
    run_op(2'd0, 32'd3, 32'd3, 5'd14, dd);                     idle(1);

    // Flush ten cycles into a multiply: no done, result keeps prior value.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 2'd0; bus.operand_a = 32'd11; bus.operand_b = 32'd13;
    bus.dest_reg = 5'd3;
    t0 = cyc;
    repeat (10) @(posedge clk);
    #1; bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_cycle_index", 64'(cyc - t0), 64'd10);
    chk("flush_stall_low", 64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("flush_busy_low", 64'(bus.busy), 64'd0);
    chk("flush_result_held", 64'(bus.result), 64'(last_res));
    idle(1);
    run_op(2'd2, 32'd9, 32'd3, 5'd4, dd);                      idle(1);

    // Asynchronous reset between clock edges while running.
    run_op(2'd0, 32'd1, 32'd1, 5'd1, dd);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 2'd0; bus.operand_a = 32'd12; bus.operand_b = 32'd13;
    bus.dest_reg = 5'd9;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("busy_mid_run", 64'(bus.busy), 64'd1);
    #2; bus.start = 1'b0; rst = 1'b1;
    #1;
    chk("async_reset", {bus.busy, bus.stall, bus.done, bus.div_by_zero, 5'(bus.result_reg), W'(bus.result)}, 64'd0);
    #1; rst = 1'b0;
    last_res = '0;

    // Back-to-back requests.
    run_op(2'd0, 32'd2, 32'd3, 5'd17, d1);
    run_op(2'd0, 32'd4, 32'd5, 5'd18, d2);
    chk("done_spacing", 64'(d2 - d1), 64'(W + 2));
    idle(1);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       begin ra = $urandom; rb = 32'd0; end
        1:       begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
        default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
      endcase
      run_op(rop, ra, rb, 5'($urandom_range(0, 31)), dd);
      idle($urandom_range(0, 2));
    end

    idle(3);
    chk("scoreboard_drain", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
